// File: rtl/hash_target_check.sv
// hash_target_check: byte-reverses a double-SHA-256 digest into Bitcoin's
// little-endian integer order and compares it to a difficulty target. The
// compare is a multi-cycle, most-significant-chunk-first magnitude compare.
// The block counts completed compares and hands winning nonces to the host
// through a valid/ack register.
// Optional feature: define HASH_CHECK_LZ_EN to add the lead_zeros output.
module hash_target_check #(
  parameter int unsigned CHUNK_W = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hash_valid,
  input  logic [255:0]       hash_in,
  input  logic [31:0]        nonce_in,
  input  logic               target_load,
  input  logic [255:0]       target_in,
  input  logic               found_ack,
  output logic               in_ready,
  output logic               found_valid,
  output logic [31:0]        found_nonce,
  output logic [CNT_W-1:0]   hashes_checked,
  output logic               overrun
`ifdef HASH_CHECK_LZ_EN
  ,
  output logic [8:0]         lead_zeros
`endif
);

  localparam int unsigned NCHUNK = 256 / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic {IDLE, CMP} state_t;

  state_t               state, state_nx;
  logic [255:0]         v_in, v_reg, target;
  logic [31:0]          nonce_reg;
  logic [IDX_W-1:0]     idx;
  logic [7:0]           shamt, base;
  logic [CHUNK_W-1:0]   v_chunk, t_chunk;
  logic                 chunk_lt, chunk_gt, last_chunk;
  logic                 decide, win;

  // Digest byte 0 becomes the least-significant byte of the compared value.
  always_comb begin
    v_in = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      v_in[8*i +: 8] = hash_in[255-8*i -: 8];
    end
  end

  // Select the current chunk of value and target, most significant first.
  always_comb begin
    shamt      = 8'(idx) * 8'(CHUNK_W);
    base       = 8'd255 - shamt;
    v_chunk    = v_reg[base -: CHUNK_W];
    t_chunk    = target[base -: CHUNK_W];
    chunk_lt   = (v_chunk < t_chunk);
    chunk_gt   = (v_chunk > t_chunk);
    last_chunk = (idx == IDX_W'(NCHUNK - 1));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and compare decision; equality on the last chunk counts as a win.
  always_comb begin
    state_nx = state;
    decide   = 1'b0;
    win      = 1'b0;
    case (state)
      IDLE: begin
        if (hash_valid) state_nx = CMP;
      end
      CMP: begin
        decide = chunk_lt | chunk_gt | last_chunk;
        win    = chunk_lt | (last_chunk & ~chunk_gt);
        if (decide) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // Capture, chunk index, target, counter, overrun and found-nonce handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_reg          <= '0;
      nonce_reg      <= '0;
      idx            <= '0;
      target         <= '1;
      found_valid    <= 1'b0;
      found_nonce    <= '0;
      hashes_checked <= '0;
      overrun        <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (target_load) target <= target_in;
        if (hash_valid) begin
          v_reg     <= v_in;
          nonce_reg <= nonce_in;
          idx       <= '0;
        end
      end else begin
        if (hash_valid) overrun <= 1'b1;
        if (!decide)    idx <= idx + IDX_W'(1);
      end

      if (decide) hashes_checked <= hashes_checked + CNT_W'(1);

      // A pending winner can be replaced only when it is acked at the same edge.
      if (decide && win) begin
        if (!found_valid || found_ack) begin
          found_nonce <= nonce_reg;
          found_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (found_ack && found_valid) begin
        found_valid <= 1'b0;
      end
    end
  end

`ifdef HASH_CHECK_LZ_EN
  logic [8:0] lz_v;

  // Leading-zero count of the whole captured value, regardless of early exit.
  always_comb begin
    lz_v = 9'd256;
    for (int unsigned i = 0; i < 256; i++) begin
      if (v_reg[i]) lz_v = 9'd255 - 9'(i);
    end
  end

  // Publish the leading-zero count at the deciding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lead_zeros <= '0;
    else if (decide) lead_zeros <= lz_v;
  end
`endif

endmodule

// File: doc/hash_target_check.md
Name: hash_target_check

Overview:
- Downstream consumer of the SHA-256 hash core.
- Accepts the final 256-bit double-hash digest and the nonce that produced it, and byte-reverses the digest into Bitcoin's little-endian integer order.
- Compares that value to the difficulty target as a multi-cycle, MS-chunk-first magnitude compare, counts the hashes it checks, and hands winning nonces to the host/UART side through a valid/ack register.

Parameters:
- CHUNK_W, 64, compare slice width; legal values 32/64/128/256. NCHUNK = 256/CHUNK_W.
- CNT_W, 32, width of the checked-hash counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- hash_valid  in  1  one-cycle pulse; hash_in/nonce_in are valid.
- hash_in  in  256  digest, {h1..h8}; hash_in[255:248] is digest byte 0.
- nonce_in  in  32  nonce belonging to hash_in.
- target_load  in  1  load target_in (honoured only in IDLE).
- target_in  in  256  target as a plain unsigned integer.
- found_ack  in  1  consumer takes found_nonce.
- in_ready  out  1  high in IDLE.
- found_valid  out  1  found_nonce holds an unconsumed winner.
- found_nonce  out  32  winning nonce.
- hashes_checked  out  CNT_W  completed compares; wraps.
- overrun  out  1  sticky; hash_valid was lost or a winner was dropped.

Behaviour:
- Reset values: state=IDLE, target=256'hFFFF...F, in_ready=1, found_valid=0, found_nonce=0, hashes_checked=0, overrun=0, idx=0.
- Byte order: V[8*i+7:8*i] = hash_in[255-8*i:248-8*i] for i=0..31. Digest byte 0 becomes the LS byte of V.
- Win condition: V <= target (unsigned).
- IDLE:
  - On hash_valid, capture V and nonce_in, set idx=0, go to CMP.
  - target_load in IDLE updates the target at the same edge. If it coincides with hash_valid, the new target applies to that hash.
- CMP, one chunk per cycle, MS first. Chunk idx = bits [255-idx*CHUNK_W -: CHUNK_W]:
  - V chunk < target chunk: WIN.
  - V chunk > target chunk: LOSE.
  - Equal and idx = NCHUNK-1: WIN.
  - Otherwise idx++.
- Decision exits immediately to IDLE. hashes_checked increments at the deciding edge.
- Latency: hash_valid sampled at edge T, decision at chunk k (0-based) → result registered at edge T+k+1. Worst case is NCHUNK cycles. in_ready is low from edge T through the deciding edge.
- WIN, found register:
  - found_valid=0 at the deciding edge: load found_nonce and set found_valid=1.
  - found_valid=1 and found_ack=1 at the same edge: load the new nonce, found_valid stays 1.
  - found_valid=1 and found_ack=0: the new winner is dropped, overrun<=1, and found_nonce is unchanged.
- found_ack with found_valid=1 and no win at that edge clears found_valid. found_ack with found_valid=0 is ignored.
- Busy conditions:
  - hash_valid while not IDLE: the input is ignored, overrun<=1, and the compare in flight is unaffected.
  - target_load while not IDLE: ignored. No flag is raised.
- overrun clears only on rst.
- rst mid-CMP: the compare is abandoned with no count and no result; all registers return to reset values, including the target.

Optional Feature:
- Macro: HASH_CHECK_LZ_EN.
- When defined: adds output lead_zeros (9 bits) = count of leading zero bits of V for the most recent completed compare, 0..256. It is updated at the deciding edge and reset to 0. It is computed from the captured V, independent of early exit.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then hash_in=0, nonce_in=32'h1234ABCD → WIN at chunk 0, found_valid=1 at edge T+1, found_nonce=32'h1234ABCD, hashes_checked=1. With LZ_EN, lead_zeros=256.
- target=256'h00000000FFFF<<208, hash_in with only hash_in[7:0]=8'h01 (V=1<<248) → LOSE at chunk 0, found_valid stays 0, hashes_checked=1.
- hash_in = byte-reverse of the target in the previous scenario, nonce 32'h5 → equal on all chunks, WIN at edge T+NCHUNK (T+4 with CHUNK_W=64), found_nonce=5.
- Winner pending, second winning hash with found_ack=0 → overrun=1, found_nonce keeps the first nonce. Repeat with found_ack=1 at the deciding edge → new nonce loaded, found_valid stays 1, overrun unchanged.
- hash_valid pulsed 1 cycle after an accepted hash that decides at the last chunk → second hash ignored, overrun=1, hashes_checked increments by 1 only.
- rst asserted asynchronously during CMP chunk 2 → all outputs at reset values immediately, target=all-ones. A following hash with V=all-ones wins (V <= target).
